// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants for the BCD <-> binary converters: FSM encodings, digit limits
// and the double-dabble correction constants for both directions.
package bcd_to_bin_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] CORR_TH  = 4'd8;
    localparam logic [3:0] CORR_SUB = 4'd3;

    // Forward (binary-to-BCD) converter uses add-3 at >= 5.
    localparam logic [3:0] ENC_TH  = 4'd5;
    localparam logic [3:0] ENC_ADD = 4'd3;

    function automatic logic digit_illegal(input logic [3:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One BCD digit correction step of reverse double-dabble: subtract 3 when the
// post-shift digit is 8 or more.
module bcd_digit_corr
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= CORR_TH) ? din - CORR_SUB : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per cycle,
// with valid/ready handshakes on both sides and registered outputs.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned SW    = 4 * DIGITS + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [1:0]       state_q;
    logic [SW-1:0]    shreg_q;
    logic [SW-1:0]    shifted;
    logic [SW-1:0]    corrected;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             out_valid_q;
    logic [BIN_W-1:0] bin_q;
    logic             in_err;

    assign shifted                = shreg_q >> 1;
    assign corrected[BIN_W-1:0]   = shifted[BIN_W-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_corr
        bcd_digit_corr u_corr (
            .din  (shifted[BIN_W+4*i +: 4]),
            .dout (corrected[BIN_W+4*i +: 4])
        );
    end

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_illegal(bcd_in[4*i +: 4])) begin
                in_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            bin_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg_q <= {bcd_in, {BIN_W{1'b0}}};
                        cnt_q   <= '0;
                        err_q   <= in_err;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    shreg_q <= corrected;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        // Illegal digits still run the full conversion but report zero.
                        bin_q       <= err_q ? '0 : corrected[BIN_W-1:0];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign err       = err_q;

endmodule
